cache_axi_bridge: RTL and testbench

//  Responder for the cache miss/uncached interface (rd_req/ret_*/wr_req): accepts one read and one write

---
 rtl/cache_axi_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// Cache miss/uncached port to AXI master bridge.
// One read and one write may be in flight; reads to a line being written wait.
module cache_axi_bridge #(
   parameter logic [3:0] RD_ID = 4'd0,
   parameter logic [3:0] WR_ID = 4'd1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rd_req,
   input  logic [2:0]   rd_type,
   input  logic [31:0]  rd_addr,
   output logic         rd_rdy,
   output logic         ret_valid,
   output logic [1:0]   ret_last,
   output logic [31:0]  ret_data,
   input  logic         wr_req,
   input  logic [2:0]   wr_type,
   input  logic [31:0]  wr_addr,
   input  logic [3:0]   wr_wstrb,
   input  logic [127:0] wr_data,
   output logic         wr_rdy,
   output logic [3:0]   arid,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic         arvalid,
   input  logic         arready,
   input  logic [3:0]   rid,
   input  logic [31:0]  rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready,
   output logic [3:0]   awid,
   output logic [31:0]  awaddr,
   output logic [7:0]   awlen,
   output logic [2:0]   awsize,
   output logic [1:0]   awburst,
   output logic         awvalid,
   input  logic         awready,
   output logic [3:0]   wid,
   output logic [31:0]  wdata,
   output logic [3:0]   wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   input  logic [3:0]   bid,
   input  logic [1:0]   bresp,
   input  logic         bvalid,
   output logic         bready
);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

   rstate_t rs, rs_n;
   wstate_t ws, ws_n;

   logic [31:0]  ra;
   logic [2:0]   rt;
   logic [31:0]  wa;
   logic [2:0]   wt;
   logic [3:0]   wm;
   logic [127:0] wd;
   logic         aw_done;
   logic         w_done;
   logic [1:0]   beat;

   logic hazard;
   logic rd_acc;
   logic wr_acc;
   logic aw_hs;
   logic w_hs;
   logic unused;

   assign unused = ^{rid, rresp, bid, bresp};

   // A same-cycle write to the same line wins; the read waits for it.
   always_comb begin
      hazard = 1'b0;
      if (ws != W_IDLE)
         hazard = (rd_addr[31:4] == wa[31:4]);
      else if (wr_req)
         hazard = (rd_addr[31:4] == wr_addr[31:4]);
   end

   assign rd_rdy = (rs == R_IDLE) && !hazard && !reset;
   assign wr_rdy = (ws == W_IDLE) && !reset;
   assign rd_acc = rd_req && rd_rdy;
   assign wr_acc = wr_req && wr_rdy;

   assign arid    = RD_ID;
   assign araddr  = ra;
   assign arlen   = rt[2] ? 8'd3 : 8'd0;
   assign arsize  = rt[2] ? 3'd2 : {1'b0, rt[1:0]};
   assign arburst = 2'b01;
   assign arvalid = (rs == R_AR);

   assign rready    = (rs == R_DATA);
   assign ret_valid = rready && rvalid;
   assign ret_data  = rdata;
   assign ret_last  = {1'b0, rlast};

   always_comb begin
      rs_n = rs;
      case (rs)
         R_IDLE: if (rd_acc) rs_n = R_AR;
         R_AR:   if (arready) rs_n = R_DATA;
         R_DATA: if (rvalid && rlast) rs_n = R_IDLE;
         default: rs_n = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs <= R_IDLE;
         ra <= '0;
         rt <= '0;
      end else begin
         rs <= rs_n;
         if (rd_acc) begin
            ra <= rd_addr;
            rt <= rd_type;
         end
      end
   end

   assign awid    = WR_ID;
   assign wid     = WR_ID;
   assign awaddr  = wa;
   assign awlen   = wt[2] ? 8'd3 : 8'd0;
   assign awsize  = wt[2] ? 3'd2 : {1'b0, wt[1:0]};
   assign awburst = 2'b01;
   assign awvalid = (ws == W_SEND) && !aw_done;
   assign wvalid  = (ws == W_SEND) && !w_done;
   assign wstrb   = wt[2] ? 4'hf : wm;
   assign wlast   = !wt[2] || (beat == 2'd3);
   assign bready  = (ws == W_RESP);

   // beat stays 0 for single-beat writes, so word0 goes out
   always_comb begin
      wdata = wd[31:0];
      case (beat)
         2'd1: wdata = wd[63:32];
         2'd2: wdata = wd[95:64];
         2'd3: wdata = wd[127:96];
         default: wdata = wd[31:0];
      endcase
   end

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   always_comb begin
      ws_n = ws;
      case (ws)
         W_IDLE: if (wr_acc) ws_n = W_SEND;
         W_SEND:
            if ((aw_done || aw_hs) && (w_done || (w_hs && wlast)))
               ws_n = W_RESP;
         W_RESP: if (bvalid) ws_n = W_IDLE;
         default: ws_n = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws      <= W_IDLE;
         wa      <= '0;
         wt      <= '0;
         wm      <= '0;
         wd      <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         beat    <= '0;
      end else begin
         ws <= ws_n;
         if (wr_acc) begin
            wa      <= wr_addr;
            wt      <= wr_type;
            wm      <= wr_wstrb;
            wd      <= wr_data;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            beat    <= '0;
         end else begin
            if (aw_hs)
               aw_done <= 1'b1;
            if (w_hs) begin
               if (wlast)
                  w_done <= 1'b1;
               else
                  beat <= beat + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Randomised bench for cache_axi_bridge: random AXI slave, transaction-level
// model of the cache port, scoreboard queues checked by a negedge monitor.
module tb_cache_axi_bridge;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic [1:0]   ret_last;
   logic [31:0]  ret_data;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid;
   logic         awready;
   logic [3:0]   wid;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic [3:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;

   cache_axi_bridge dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
      .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
      .ret_data(ret_data),
      .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
      .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   localparam int NOPS = 60;

   int vecs = 0;
   int errs = 0;
   int ret_cnt = 0;

   logic [63:0] q_ar[$];
   logic [63:0] q_ret[$];
   logic [63:0] q_aw[$];
   logic [63:0] q_w[$];

   logic        rbusy = 1'b0;
   logic        wbusy = 1'b0;
   logic [27:0] wline = '0;
   logic        exp_rr;

   logic        ar_hs = 1'b0;
   logic        r_hs = 1'b0;
   logic        aw_hs = 1'b0;
   logic        wl_hs = 1'b0;
   logic        b_hs = 1'b0;
   logic [31:0] cap_ra = '0;
   logic [7:0]  cap_len = '0;

   logic        ar_pend = 1'b0;
   logic        aw_pend = 1'b0;
   logic        w_pend = 1'b0;
   logic [63:0] ar_prev, aw_prev, w_prev;
   logic [63:0] ar_now, aw_now, w_now;

   logic [2:0]  r_sel, w_sel;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
   endfunction

   function automatic int nbeats(input logic [2:0] t);
      return t[2] ? 4 : 1;
   endfunction

   function automatic logic [2:0] log2bytes(input logic [2:0] t);
      int bytes;
      bytes = t[2] ? 4 : (1 << t[1:0]);
      return 3'($clog2(bytes));
   endfunction

   function automatic logic [63:0] mk_a(input logic [3:0] id,
                                        input logic [31:0] a,
                                        input logic [2:0] t);
      logic [7:0] len;
      len = 8'(nbeats(t) - 1);
      return {15'b0, id, a, len, log2bytes(t), 2'b01};
   endfunction

   function automatic logic [2:0] pick_type();
      logic [2:0] tab [4];
      tab[0] = 3'b000;
      tab[1] = 3'b001;
      tab[2] = 3'b010;
      tab[3] = 3'b100;
      return tab[$urandom_range(0, 3)];
   endfunction

   function automatic logic [31:0] pick_addr(input logic [2:0] t);
      logic [31:0] a;
      a = 32'h1C00_0000 | (32'($urandom_range(0, 3)) << 4);
      if (t == 3'b000) a = a | 32'($urandom_range(0, 15));
      else if (t == 3'b001) a = a | 32'(2 * $urandom_range(0, 7));
      else if (t == 3'b010) a = a | 32'(4 * $urandom_range(0, 3));
      return a;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic miss(input string nm);
      vecs++;
      errs++;
      $display("FAIL %s: output with no expected entry", nm);
   endtask

   assign ar_now = {15'b0, arid, araddr, arlen, arsize, arburst};
   assign aw_now = {15'b0, awid, awaddr, awlen, awsize, awburst};
   assign w_now  = {23'b0, wid, wdata, wstrb, wlast};

   // monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         ar_hs = 0; r_hs = 0; aw_hs = 0; wl_hs = 0; b_hs = 0;
         ar_pend = 0; aw_pend = 0; w_pend = 0;
      end else begin
         exp_rr = !rbusy && !(wbusy ? (rd_addr[31:4] == wline)
                  : (wr_req && rd_addr[31:4] == wr_addr[31:4]));
         chk("rd_rdy", 64'(rd_rdy), 64'(exp_rr));
         chk("wr_rdy", 64'(wr_rdy), 64'(!wbusy));
         if (ar_pend) chk("ar_hold", {arvalid, ar_now[62:0]}, {1'b1, ar_prev[62:0]});
         if (aw_pend) chk("aw_hold", {awvalid, aw_now[62:0]}, {1'b1, aw_prev[62:0]});
         if (w_pend) chk("w_hold", {wvalid, w_now[62:0]}, {1'b1, w_prev[62:0]});
         ar_pend = arvalid && !arready; ar_prev = ar_now;
         aw_pend = awvalid && !awready; aw_prev = aw_now;
         w_pend = wvalid && !wready; w_prev = w_now;

         ar_hs = arvalid && arready;
         r_hs = rvalid && rready;
         aw_hs = awvalid && awready;
         wl_hs = wvalid && wready && wlast;
         b_hs = bvalid && bready;

         if (ar_hs) begin
            cap_ra = araddr;
            cap_len = arlen;
            if (q_ar.size() == 0) miss("ar");
            else chk("ar", ar_now, q_ar.pop_front());
         end
         if (ret_valid) begin
            ret_cnt++;
            if (q_ret.size() == 0) miss("ret");
            else chk("ret", {30'b0, ret_last, ret_data}, q_ret.pop_front());
            if (ret_last[0]) rbusy = 1'b0;
         end
         if (aw_hs) begin
            if (q_aw.size() == 0) miss("aw");
            else chk("aw", aw_now, q_aw.pop_front());
         end
         if (wvalid && wready) begin
            if (q_w.size() == 0) miss("w");
            else chk("w", w_now, q_w.pop_front());
         end
         if (b_hs) wbusy = 1'b0;

         if (rd_req && rd_rdy) begin
            rbusy = 1'b1;
            q_ar.push_back(mk_a(4'd0, rd_addr, rd_type));
            for (int i = 0; i < nbeats(rd_type); i++)
               q_ret.push_back({30'b0, 1'b0, i == nbeats(rd_type) - 1,
                                pat(rd_addr + 32'(4 * i))});
         end
         if (wr_req && wr_rdy) begin
            wbusy = 1'b1;
            wline = wr_addr[31:4];
            q_aw.push_back(mk_a(4'd1, wr_addr, wr_type));
            if (wr_type[2]) begin
               for (int i = 0; i < 4; i++)
                  q_w.push_back({23'b0, 4'd1, wr_data[32*i +: 32], 4'hf, i == 3});
            end else begin
               q_w.push_back({23'b0, 4'd1, wr_data[31:0], wr_wstrb, 1'b1});
            end
         end
      end
   end

   // AXI read slave
   int rsl = 0;
   int rbeat = 0;
   initial begin
      arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 0; rresp = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            rsl = 0; arready = 0; rvalid = 0; rlast = 0;
         end else if (rsl == 0) begin
            if (ar_hs) begin
               rsl = 1; rbeat = 0; arready = 0;
               rvalid = 1'($urandom_range(0, 1));
            end else begin
               arready = 1'($urandom_range(0, 1));
            end
         end else begin
            if (r_hs) begin
               if (rbeat == int'(cap_len)) begin
                  rsl = 0; rvalid = 0;
               end else begin
                  rbeat++;
                  rvalid = 1'($urandom_range(0, 1));
               end
            end else if (!rvalid) begin
               rvalid = 1'($urandom_range(0, 1));
            end
         end
         rdata = pat(cap_ra + 32'(4 * rbeat));
         rlast = (rsl == 1) && (rbeat == int'(cap_len));
      end
   end

   // AXI write slave; awready is biased low so W often finishes first
   logic aw_got = 0;
   logic w_got = 0;
   initial begin
      awready = 0; wready = 0; bvalid = 0; bid = 4'd1; bresp = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            awready = 0; wready = 0; bvalid = 0; aw_got = 0; w_got = 0;
         end else begin
            if (aw_hs) aw_got = 1;
            if (wl_hs) w_got = 1;
            if (b_hs) begin
               bvalid = 0; aw_got = 0; w_got = 0;
            end else if (aw_got && w_got && !bvalid) begin
               bvalid = 1'($urandom_range(0, 1));
            end
            awready = !aw_got && ($urandom_range(0, 3) == 0);
            wready = !w_got && ($urandom_range(0, 1) == 1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int k;
   int base;
   initial begin
      reset = 1; rd_req = 0; wr_req = 0;
      rd_type = 0; rd_addr = 0; wr_type = 0; wr_addr = 0;
      wr_wstrb = 0; wr_data = 0;
      #2;
      chk("reset_outs",
          64'({arvalid, awvalid, wvalid, rready, bready, ret_valid, rd_rdy, wr_rdy}),
          64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 0;

      fork
         begin
            for (int i = 0; i < NOPS; i++) begin
               @(posedge clk);
               #1;
               r_sel = pick_type();
               rd_type = r_sel;
               rd_addr = pick_addr(r_sel);
               rd_req = 1;
               @(negedge clk);
               while (!rd_rdy) @(negedge clk);
               @(posedge clk);
               #1 rd_req = 0;
               repeat ($urandom_range(0, 3)) @(posedge clk);
            end
         end
         begin
            for (int i = 0; i < NOPS; i++) begin
               @(posedge clk);
               #1;
               while (!wr_rdy) begin
                  @(posedge clk);
                  #1;
               end
               w_sel = pick_type();
               wr_type = w_sel;
               wr_addr = pick_addr(w_sel);
               wr_wstrb = 4'($urandom_range(1, 15));
               wr_data = {$urandom, $urandom, $urandom, $urandom};
               wr_req = 1;
               @(posedge clk);
               #1 wr_req = 0;
               repeat ($urandom_range(0, 4)) @(posedge clk);
            end
         end
      join

      k = 0;
      while (k < 2000 && (rbusy || wbusy || q_ar.size() != 0 ||
             q_ret.size() != 0 || q_aw.size() != 0 || q_w.size() != 0)) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (k >= 2000) begin
         vecs++;
         errs++;
         $display("FAIL drain: transactions outstanding at end, got busy expected idle");
      end

      // reset during the second beat of a line read
      @(posedge clk);
      #1;
      rd_type = 3'b100;
      rd_addr = 32'h1C00_0040;
      rd_req = 1;
      @(negedge clk);
      while (!rd_rdy) @(negedge clk);
      @(posedge clk);
      #1 rd_req = 0;
      base = ret_cnt;
      k = 0;
      while (!(ret_valid && ret_cnt == base + 1) && k < 200) begin
         @(posedge clk);
         #2;
         k++;
      end
      if (k >= 200) begin
         vecs++;
         errs++;
         $display("FAIL beat2_wait: got no second beat expected one");
      end
      reset = 1;
      #1;
      chk("reset_async", 64'({rready, arvalid, ret_valid, rd_rdy, wr_rdy}), 64'd0);
      q_ar.delete(); q_ret.delete(); q_aw.delete(); q_w.delete();
      rbusy = 0;
      wbusy = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      #1;
      chk("rd_rdy_after_reset", 64'(rd_rdy), 64'd1);
      chk("wr_rdy_after_reset", 64'(wr_rdy), 64'd1);
      chk("idle_after_reset", 64'({arvalid, awvalid, rready, bready}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
